// File: rtl/reaction_timer.sv
// reaction_timer: waits a random delay, lights Led, times the button press.
// Ports: Clk, Rst, Start, Button, RandomValue in; Led, ReactionTime, Done,
//        EarlyPress, Timeout, Busy out. Times are in ms ticks.
module reaction_timer #(
  parameter int CLKS_PER_MS = 1000,
  parameter int MAX_MS      = 9999
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Button,
  input  logic [13:0] RandomValue,
  output logic        Led,
  output logic [13:0] ReactionTime,
  output logic        Done,
  output logic        EarlyPress,
  output logic        Timeout,
  output logic        Busy
);

  localparam int PW =
    (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(CLKS_PER_MS - 1);
  localparam logic [13:0] MAXV  = 14'(MAX_MS);
  localparam logic [13:0] MAXM1 = 14'(MAX_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REACT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [13:0]     delay_q, delay_d;
  logic [13:0]     react_q, react_d;
  logic [13:0]     rt_q, rt_d;
  logic            btn_q;
  logic            done_q, done_d;
  logic            early_q, early_d;
  logic            tmo_q, tmo_d;

  logic press;
  logic tick;
  logic last_ms;

  assign press   = Button & ~btn_q;
  assign tick    = (presc_q == LAST);
  // Final tick of REACT: the counter would reach MAX_MS on this edge.
  assign last_ms = tick && (react_q == MAXM1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      delay_q <= '0;
      react_q <= '0;
      rt_q    <= '0;
      btn_q   <= Button;
      done_q  <= 1'b0;
      early_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      delay_q <= delay_d;
      react_q <= react_d;
      rt_q    <= rt_d;
      btn_q   <= Button;
      done_q  <= done_d;
      early_q <= early_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = '0;
    delay_d = delay_q;
    react_d = react_q;
    rt_d    = rt_q;
    done_d  = 1'b0;
    early_d = early_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_WAIT;
          delay_d = (RandomValue == 14'd0) ?
                    14'd1 : RandomValue;
          early_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_WAIT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        // Early press beats a coincident final tick.
        if (press) begin
          state_d = S_IDLE;
          presc_d = '0;
          early_d = 1'b1;
          done_d  = 1'b1;
        end else if (tick) begin
          if (delay_q == 14'd1) begin
            state_d = S_REACT;
            presc_d = '0;
            react_d = '0;
          end else begin
            delay_d = delay_q - 14'd1;
          end
        end
      end
      S_REACT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (press) begin
          state_d = S_IDLE;
          presc_d = '0;
          rt_d    = last_ms ? MAXV : react_q;
          done_d  = 1'b1;
        end else if (last_ms) begin
          state_d = S_IDLE;
          presc_d = '0;
          rt_d    = MAXV;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end else if (tick) begin
          react_d = react_q + 14'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Led          = (state_q == S_REACT);
  assign Busy         = (state_q != S_IDLE);
  assign ReactionTime = rt_q;
  assign Done         = done_q;
  assign EarlyPress   = early_q;
  assign Timeout      = tmo_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: random and directed trials against an
// arithmetic per-trial outcome model.
module tb_reaction_timer;

  localparam int C   = 4;
  localparam int MX  = 20;
  localparam int NONE = 100000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic        Button;
  logic [13:0] RandomValue;
  logic        Led;
  logic [13:0] ReactionTime;
  logic        Done;
  logic        EarlyPress;
  logic        Timeout;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  int exp_rt = 0;

  reaction_timer #(
    .CLKS_PER_MS(C),
    .MAX_MS     (MX)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .Button      (Button),
    .RandomValue (RandomValue),
    .Led         (Led),
    .ReactionTime(ReactionTime),
    .Done        (Done),
    .EarlyPress  (EarlyPress),
    .Timeout     (Timeout),
    .Busy        (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle (or in its Done cycle).
  // d: delay value, p: edge (after the accept edge = 0) on which the
  // press is sampled, or NONE. Returns at the negedge after the end.
  task automatic run_trial(
    input int d,
    input int p,
    input bit btn0,
    input bit chain
  );
    int dp, l, e, r, rt_new;
    bit early, tmo;
    dp = (d == 0) ? 1 : d;
    l  = dp * C;
    early = 0;
    tmo   = 0;
    rt_new = exp_rt;
    if (p <= l) begin
      early = 1;
      e = p;
    end else begin
      r = p - l;
      if (r <= MX * C) begin
        e = p;
        rt_new = (r == MX * C) ? MX : (r - 1) / C;
      end else begin
        e = l + MX * C;
        rt_new = MX;
        tmo = 1;
      end
    end
    Start       = 1'b1;
    RandomValue = 14'(d);
    Button      = btn0;
    for (int n = 0; n <= e; n++) begin
      @(negedge Clk);
      chk("led", Led, (n >= l && n < e));
      chk("busy", Busy, (n < e));
      chk("done", Done, (n == e));
      if (n < e) begin
        chk("early_run", EarlyPress, 0);
        chk("tmo_run", Timeout, 0);
        chk("rt_hold", ReactionTime, exp_rt);
        Start       = 1'($urandom_range(0, 1));
        RandomValue = 14'($urandom);
        if (n == 0 && btn0) Button = 1'b0;
        if (n == p - 1) Button = 1'b1;
      end else begin
        exp_rt = rt_new;
        chk("early", EarlyPress, early);
        chk("tmo", Timeout, tmo);
        chk("rt", ReactionTime, exp_rt);
        Start  = chain;
        Button = 1'b0;
      end
    end
  endtask

  task automatic idle_chk(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge Clk);
      chk("idle_done", Done, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_led", Led, 0);
      chk("idle_rt", ReactionTime, exp_rt);
    end
  endtask

  initial begin
    int d, l, p;
    bit ch;
    Rst         = 1'b1;
    Start       = 1'b0;
    Button      = 1'b1;
    RandomValue = '0;
    repeat (2) @(negedge Clk);
    chk("rst_led", Led, 0);
    chk("rst_done", Done, 0);
    chk("rst_early", EarlyPress, 0);
    chk("rst_tmo", Timeout, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_rt", ReactionTime, 0);
    Rst = 1'b0;
    @(negedge Clk);

    // Button held through reset, then a full timeout trial.
    run_trial(2, NONE, 1'b1, 1'b0);
    idle_chk(2);
    // Normal: press sampled 10 edges after Led rises.
    run_trial(3, 12 + 10, 1'b0, 1'b0);
    idle_chk(2);
    // Early press.
    run_trial(5, 6, 1'b0, 1'b0);
    idle_chk(2);
    // Timeout.
    run_trial(1, NONE, 1'b0, 1'b0);
    idle_chk(2);
    // Zero delay, then back-to-back with Start held over Done.
    run_trial(0, 4 + 5, 1'b0, 1'b1);
    run_trial(0, 3, 1'b0, 1'b1);
    run_trial(2, NONE, 1'b0, 1'b1);
    run_trial(1, 6, 1'b0, 1'b0);
    idle_chk(2);
    // Press on the final WAIT tick, and on the final REACT tick.
    run_trial(2, 8, 1'b0, 1'b0);
    idle_chk(1);
    run_trial(1, 4 + MX * C, 1'b0, 1'b0);
    idle_chk(1);

    // Reset while Led is lit.
    Start       = 1'b1;
    RandomValue = 14'd1;
    for (int n = 0; n <= 5; n++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    chk("mid_led_on", Led, 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst    = 1'b0;
    exp_rt = 0;
    chk("mid_led", Led, 0);
    chk("mid_busy", Busy, 0);
    chk("mid_done", Done, 0);
    chk("mid_rt", ReactionTime, 0);
    idle_chk(2);

    for (int t = 0; t < 40; t++) begin
      d = $urandom_range(0, 4);
      l = ((d == 0) ? 1 : d) * C;
      if ($urandom_range(0, 3) == 0) p = NONE;
      else p = $urandom_range(1, l + MX * C + 6);
      ch = 1'($urandom_range(0, 1));
      run_trial(d, p, 1'b0, ch);
      if (!ch) idle_chk($urandom_range(1, 3));
    end
    Start = 1'b0;
    idle_chk(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
